// File: rtl/ifetch_queue.sv
// Instruction prefetch queue: streams sequential words from an in-order memory port into an
// address-tagged FIFO and presents the word matching the core's PC. Optional IFQ_BYPASS_EN forwards a miss response same-cycle.
module ifetch_queue #(
  parameter int          DEPTH    = 4,
  parameter int          MAX_OUT  = 2,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_i,
  input  logic        pc_take,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W:0]   DEPTH_V   = (CNT_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] MAX_OUT_V = CNT_W'(MAX_OUT);

  logic [31:0]      addrMem [DEPTH];
  logic [31:0]      dataMem [DEPTH];
  logic [PTR_W-1:0] headPtr, tailPtr, headNext, tailNext;
  logic [CNT_W-1:0] count, countNext;
  logic [CNT_W-1:0] outstanding, outNext;
  logic [CNT_W-1:0] drop, dropNext;
  logic [31:0]      fetchAddr, fetchNext;
  logic [31:0]      respAddr, respNext;
  logic [31:0]      headAddr, headData, streamPc;
  logic [CNT_W:0]   occupancy;
  logic             hit, redirect, issue, pop, pushEn, respLive;
  logic             bypassHit, bypassTake;

  assign headAddr = addrMem[headPtr];
  assign headData = dataMem[headPtr];

  // The address the core should be asking for if no control transfer happened.
  always_comb begin
    streamPc = fetchAddr;
    if (count != '0)
      streamPc = headAddr;
    else if (outstanding > drop)
      streamPc = respAddr;
  end

  assign hit      = (count != '0) && (headAddr == pc_i);
  assign redirect = (pc_i != streamPc);

  // Slots already promised: queued words plus live (non-dropped) requests in flight.
  assign occupancy = {1'b0, count} + {1'b0, outstanding} - {1'b0, drop};

  assign imem_req  = reset && !redirect && (occupancy < DEPTH_V) && (outstanding < MAX_OUT_V);
  assign imem_addr = fetchAddr;
  assign issue     = imem_req && imem_gnt;
  assign respLive  = imem_rvalid && (drop == '0);

`ifdef IFQ_BYPASS_EN
  assign bypassHit = reset && (count == '0) && respLive && (respAddr == pc_i);
`else
  assign bypassHit = 1'b0;
`endif
  assign bypassTake = bypassHit && pc_take;

  assign pop         = pc_take && hit;
  assign instr_valid = reset && (hit || bypassHit);
  assign instr       = hit ? headData : (bypassHit ? imem_rdata : 32'h0);

  assign pushEn = !redirect && respLive && !bypassTake;

  always_comb begin
    countNext = count;
    headNext  = headPtr;
    tailNext  = tailPtr;
    fetchNext = fetchAddr;
    respNext  = respAddr;
    outNext   = outstanding;
    dropNext  = drop;
    if (redirect) begin
      // Every request still in flight after this edge belongs to the old stream.
      countNext = '0;
      headNext  = '0;
      tailNext  = '0;
      fetchNext = pc_i;
      respNext  = pc_i;
      outNext   = outstanding - CNT_W'(imem_rvalid);
      dropNext  = outstanding - CNT_W'(imem_rvalid);
    end else begin
      if (issue)
        fetchNext = fetchAddr + 32'd4;
      outNext = outstanding + CNT_W'(issue) - CNT_W'(imem_rvalid);
      if (imem_rvalid) begin
        if (drop != '0)
          dropNext = drop - 1'b1;
        else
          respNext = respAddr + 32'd4;
      end
      if (pushEn)
        tailNext = tailPtr + 1'b1;
      if (pop)
        headNext = headPtr + 1'b1;
      countNext = count + CNT_W'(pushEn) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      headPtr     <= '0;
      tailPtr     <= '0;
      count       <= '0;
      outstanding <= '0;
      drop        <= '0;
      fetchAddr   <= RESET_PC;
      respAddr    <= RESET_PC;
      for (int i = 0; i < DEPTH; i++) begin
        addrMem[i] <= '0;
        dataMem[i] <= '0;
      end
    end else begin
      headPtr     <= headNext;
      tailPtr     <= tailNext;
      count       <= countNext;
      outstanding <= outNext;
      drop        <= dropNext;
      fetchAddr   <= fetchNext;
      respAddr    <= respNext;
      if (pushEn) begin
        addrMem[tailPtr] <= respAddr;
        dataMem[tailPtr] <= imem_rdata;
      end
    end
  end

endmodule
